// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate extender for full instruction words.
// Decodes the format (from the opcode or an explicit one-hot select), builds
// the XLEN-wide immediate at write time and queues it with its tag in a
// 2-entry elastic buffer with valid/ready handshakes and synchronous flush.
module imm_gen_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter bit          AUTO_DECODE = 1'b1,
    parameter int unsigned TAG_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [6:0]       ext_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [6:0]       out_fmt,
    output logic             out_fmt_err,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [6:0] {
        FMT_NONE  = 7'b0000000,
        FMT_SHAMT = 7'b0000001,
        FMT_I     = 7'b0000010,
        FMT_S     = 7'b0000100,
        FMT_B     = 7'b0001000,
        FMT_U     = 7'b0010000,
        FMT_J     = 7'b0100000,
        FMT_Z     = 7'b1000000
    } fmt_e;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_IMM32  = 7'b0011011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic            ext_onehot;
    logic [6:0]      fmt_sel;
    logic            fmt_err;
    logic [63:0]     imm64;
    logic [XLEN-1:0] imm_new;

    logic            push;
    logic            pop;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    logic [XLEN-1:0]  mem_imm [2];
    logic [6:0]       mem_fmt [2];
    logic             mem_err [2];
    logic [TAG_W-1:0] mem_tag [2];

    assign opcode     = in_inst[6:0];
    assign funct3     = in_inst[14:12];
    assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign ext_onehot = (ext_op != 7'd0) && ((ext_op & (ext_op - 7'd1)) == 7'd0);

    // Select the format from the opcode or from the one-hot ext_op; flag errors.
    always_comb begin
        fmt_sel = FMT_NONE;
        fmt_err = 1'b0;
        if (AUTO_DECODE) begin
            case (opcode)
                OP_LOAD, OP_JALR: fmt_sel = FMT_I;
                OP_IMM:           fmt_sel = is_shift ? FMT_SHAMT : FMT_I;
                OP_IMM32: begin
                    if (XLEN == 64) fmt_sel = is_shift ? FMT_SHAMT : FMT_I;
                    else            fmt_err = 1'b1;
                end
                OP_STORE:         fmt_sel = FMT_S;
                OP_BRANCH:        fmt_sel = FMT_B;
                OP_LUI, OP_AUIPC: fmt_sel = FMT_U;
                OP_JAL:           fmt_sel = FMT_J;
                OP_SYSTEM:        fmt_sel = funct3[2] ? FMT_Z : FMT_I;
                default:          fmt_err = 1'b1;
            endcase
        end else begin
            if (ext_onehot) fmt_sel = ext_op;
            else            fmt_err = 1'b1;
        end
    end

    // Build the immediate at 64 bits, then keep the low XLEN bits.
    always_comb begin
        imm64 = '0;
        case (fmt_sel)
            FMT_I: imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
            FMT_S: imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: imm64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
            FMT_J: imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            FMT_SHAMT: begin
                if ((XLEN == 64) && (opcode != OP_IMM32))
                    imm64 = {58'b0, in_inst[25:20]};
                else
                    imm64 = {59'b0, in_inst[24:20]};
            end
            FMT_Z:   imm64 = {59'b0, in_inst[19:15]};
            default: imm64 = '0;
        endcase
    end

    assign imm_new   = imm64[XLEN-1:0];

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Buffer state: flush beats push/pop; payload is kept across pop and flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem_imm[i] <= '0;
                mem_fmt[i] <= '0;
                mem_err[i] <= 1'b0;
                mem_tag[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem_imm[wr_ptr] <= imm_new;
                mem_fmt[wr_ptr] <= fmt_sel;
                mem_err[wr_ptr] <= fmt_err;
                mem_tag[wr_ptr] <= in_tag;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_imm     = mem_imm[rd_ptr];
    assign out_fmt     = mem_fmt[rd_ptr];
    assign out_fmt_err = mem_err[rd_ptr];
    assign out_tag     = mem_tag[rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed testbench for imm_gen_pipe: three instances (XLEN=32 auto,
// XLEN=32 explicit ext_op, XLEN=64 auto) share one input stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic [6:0]  ext_op;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_fmt_err;
    logic [31:0] a_out_imm, a_out_tag;
    logic [6:0]  a_out_fmt;

    logic        m_in_ready, m_out_valid, m_out_fmt_err;
    logic [31:0] m_out_imm, m_out_tag;
    logic [6:0]  m_out_fmt;

    logic        w_in_ready, w_out_valid, w_out_fmt_err;
    logic [63:0] w_out_imm;
    logic [31:0] w_out_tag;
    logic [6:0]  w_out_fmt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .TAG_W(32)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .ext_op(ext_op), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_fmt_err(a_out_fmt_err),
        .out_tag(a_out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(32)) dut_m (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_ready(m_in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .ext_op(ext_op), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_imm(m_out_imm), .out_fmt(m_out_fmt), .out_fmt_err(m_out_fmt_err),
        .out_tag(m_out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(32)) dut_w (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_ready(w_in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .ext_op(ext_op), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_imm(w_out_imm), .out_fmt(w_out_fmt), .out_fmt_err(w_out_fmt_err),
        .out_tag(w_out_tag)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for a single cycle; the tag carries the instruction word.
    task automatic push1(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
        in_tag   = inst;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] inst,
                         input logic [31:0] imm, input logic [6:0] fmt, input logic err);
        check({tag, "_valid"}, a_out_valid, 1);
        check({tag, "_imm"}, a_out_imm, imm);
        check({tag, "_fmt"}, a_out_fmt, fmt);
        check({tag, "_err"}, a_out_fmt_err, err);
        check({tag, "_tag"}, a_out_tag, inst);
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_tag    = '0;
        ext_op    = 7'b0000010;
        out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_imm", a_out_imm, 0);
        check("rst_out_fmt", a_out_fmt, 0);
        check("rst_out_err", a_out_fmt_err, 0);
        check("rst_out_tag", a_out_tag, 0);
        check("rst_w_imm", w_out_imm, 0);
        step();
        rstn = 1'b1;
        step();

        // Auto decode, XLEN=32 (latency 1, back-to-back with out_ready=1)
        push1(32'hFFF00093); chk_a("addi", 32'hFFF00093, 32'hFFFFFFFF, 7'b0000010, 1'b0);
        push1(32'hFE112E23); chk_a("sw",   32'hFE112E23, 32'hFFFFFFFC, 7'b0000100, 1'b0);
        push1(32'hFE000EE3); chk_a("beq",  32'hFE000EE3, 32'hFFFFFFFC, 7'b0001000, 1'b0);
        push1(32'h123452B7); chk_a("lui",  32'h123452B7, 32'h12345000, 7'b0010000, 1'b0);
        check("lui_w64", w_out_imm, 64'h0000000012345000);
        push1(32'h01F09093); chk_a("slli", 32'h01F09093, 32'h0000001F, 7'b0000001, 1'b0);
        push1(32'h01FFD073); chk_a("csri", 32'h01FFD073, 32'h0000001F, 7'b1000000, 1'b0);
        // jal -4: imm[20|10:1|11|19:12] all ones except bit1..0 pattern
        push1(32'hFFDFF06F); chk_a("jal",  32'hFFDFF06F, 32'hFFFFFFFC, 7'b0100000, 1'b0);
        // csrrs (funct3[2]=0) is I
        push1(32'h80002073); chk_a("csrrs", 32'h80002073, 32'hFFFFF800, 7'b0000010, 1'b0);

        // Errors, auto mode
        push1(32'h0000007F); chk_a("badop", 32'h0000007F, 32'h0, 7'b0, 1'b1);
        push1(32'h03F0909B);
        chk_a("op32_on_rv32", 32'h03F0909B, 32'h0, 7'b0, 1'b1);
        check("slliw_w64_imm", w_out_imm, 64'h1F);
        check("slliw_w64_fmt", w_out_fmt, 7'b0000001);

        // XLEN=64 vectors
        push1(32'h800002B7);
        check("lui64_imm", w_out_imm, 64'hFFFFFFFF80000000);
        check("lui64_fmt", w_out_fmt, 7'b0010000);
        check("lui32_imm", a_out_imm, 32'h80000000);
        push1(32'h03F09093);
        check("slli63_w64", w_out_imm, 64'h3F);
        check("slli63_rv32", a_out_imm, 32'h1F);

        // Explicit ext_op instance
        ext_op = 7'b0000011;
        push1(32'hFE000EE3);
        check("m_twohot_err", m_out_fmt_err, 1);
        check("m_twohot_fmt", m_out_fmt, 0);
        check("m_twohot_imm", m_out_imm, 0);
        ext_op = 7'b0000000;
        push1(32'hFE000EE3);
        check("m_zero_err", m_out_fmt_err, 1);
        ext_op = 7'b0001000;
        push1(32'hFE000EE3);
        check("m_b_imm", m_out_imm, 32'hFFFFFFFC);
        check("m_b_fmt", m_out_fmt, 7'b0001000);
        check("m_b_err", m_out_fmt_err, 0);
        ext_op = 7'b0000010;
        step();
        check("drain_empty", a_out_valid, 0);

        // Backpressure: three back-to-back words with out_ready=0
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst = 32'h00100093; in_tag = 32'h11;
        step();
        check("bp_ready_after1", a_in_ready, 1);
        in_inst = 32'h00200093; in_tag = 32'h22;
        step();
        check("bp_ready_full", a_in_ready, 0);
        in_inst = 32'h00300093; in_tag = 32'h33;
        step();
        check("bp_still_full", a_in_ready, 0);
        check("bp_hold_imm", a_out_imm, 32'h1);
        check("bp_hold_tag", a_out_tag, 32'h11);
        out_ready = 1'b1;
        step();
        check("bp_pop1_ready", a_in_ready, 1);
        check("bp_pop1_imm", a_out_imm, 32'h2);
        step();
        in_valid = 1'b0;
        check("bp_third_imm", a_out_imm, 32'h3);
        check("bp_third_tag", a_out_tag, 32'h33);
        step();
        check("bp_empty", a_out_valid, 0);

        // Flush with two entries buffered and a word offered
        out_ready = 1'b0;
        push1(32'h00400093);
        push1(32'h00500093);
        in_valid = 1'b1; in_inst = 32'h00600093; in_tag = 32'h66;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_valid", a_out_valid, 0);
        check("fl2_ready", a_in_ready, 1);
        // Flush with one entry buffered: the offered word must be dropped
        push1(32'h00700093);
        in_valid = 1'b1; in_inst = 32'h00800093; in_tag = 32'h88;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl1_valid", a_out_valid, 0);
        out_ready = 1'b1;
        step();
        check("fl1_no_ghost", a_out_valid, 0);
        push1(32'h00900093);
        check("fl_after_imm", a_out_imm, 32'h9);
        check("fl_after_tag", a_out_tag, 32'h00900093);
        step();

        // Asynchronous reset mid-stream with two entries
        out_ready = 1'b0;
        push1(32'h00A00093);
        push1(32'h00B00093);
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", a_out_valid, 0);
        check("arst_ready", a_in_ready, 1);
        check("arst_imm", a_out_imm, 0);
        check("arst_tag", a_out_tag, 0);
        step();
        #2 rstn = 1'b1;
        out_ready = 1'b1;
        step();
        check("arst_idle", a_out_valid, 0);
        push1(32'h00C00093);
        check("arst_lat_valid", a_out_valid, 1);
        check("arst_lat_imm", a_out_imm, 32'hC);
        step();
        check("arst_final_empty", a_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined successor to the decode-stage immediate extender. It takes full instruction words rather than pre-sliced fields and handles I/S/B/U/J/shamt/CSR-zimm formats. It either derives the format from the opcode (auto mode) or takes an explicit one-hot format select. Results pass through a 2-entry elastic buffer with valid/ready handshakes and pipeline flush, between fetch/IF-ID and the ID-stage operand mux.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- AUTO_DECODE, 1: 1 = format from opcode, ext_op ignored; 0 = format from ext_op.
- TAG_W, 32: width of sideband tag (PC) carried alongside each word.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all buffered entries and any same-cycle input.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  buffer can accept; equals (count != 2), from registered state only.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- ext_op  in  7  one-hot format: bit0 SHAMT, bit1 I, bit2 S, bit3 B, bit4 U, bit5 J, bit6 Z.
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  consumer takes head.
- out_imm  out  XLEN  extended immediate of head entry.
- out_fmt  out  7  one-hot format actually applied (same bit map as ext_op); 0 on error.
- out_fmt_err  out  1  unknown opcode or ext_op not exactly one-hot.
- out_tag  out  TAG_W  tag of head entry.

## Operation
- Immediate rules (sext/zext to XLEN):
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25],inst[11:7]}).
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - U: sext({inst[31:12],12'b0}); sign-extends above bit 31 when XLEN=64.
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - SHAMT: zext(inst[24:20]) for XLEN=32; zext(inst[25:20]) for XLEN=64, except opcode 0011011, which uses 5 bits.
  - Z: zext(inst[19:15]).
- Auto decode, by opcode:
  - 0000011 and 1100111 → I.
  - 0010011 → SHAMT if funct3 is 001 or 101, else I.
  - 0011011 (XLEN=64 only) → SHAMT if funct3 is 001 or 101, else I.
  - 0100011 → S; 1100011 → B; 0110111 and 0010111 → U; 1101111 → J.
  - 1110011 → Z if funct3[2]=1, else I.
  - Anything else → error.
- Error entry: out_imm=0, out_fmt=0, out_fmt_err=1. The entry is still buffered and delivered in order.
- Buffer: 2-entry FIFO (wr_ptr, rd_ptr, 2-bit count). Immediate is computed combinationally at write and stored with fmt, err and tag.
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
- Simultaneous push and pop at count=1: count stays 1, order preserved.
- At count=2, in_ready=0. A pop that cycle makes in_ready=1 the next cycle (no same-cycle pass-through).
- Flush has priority over push and pop: count←0 and pointers←0 next edge.

## Timing
- Reset (rstn=0, asynchronous):
  - count, pointers, out_valid ← 0.
  - out_imm, out_fmt, out_tag ← 0; out_fmt_err ← 0.
  - in_ready = 1 immediately.
- Latency: a word accepted at edge N is presented on out_* after edge N, so out_valid=1 in cycle N+1.
- Throughput: 1 word/cycle while out_ready=1.
- out_* fields are held stable while out_valid=1 and out_ready=0.
- Stored-entry payload is not cleared on pop or flush; only out_valid gates it.
- rstn asserted mid-transfer drops all entries; no partial state survives.

## Test plan
- Auto, XLEN=32:
  - 0xFFF00093 (addi x1,x0,-1) → out_imm=0xFFFFFFFF, out_fmt=0000010.
  - 0xFE112E23 (sw) → 0xFFFFFFFC, fmt S.
  - 0xFE000EE3 (beq -4) → 0xFFFFFFFC, fmt B.
  - 0x123452B7 (lui) → 0x12345000, fmt U.
  - 0x01F09093 (slli 31) → 0x1F, fmt SHAMT.
  - 0x01FFD073 (csrrwi zimm=31) → 0x1F, fmt Z.
- Backpressure: out_ready=0, drive 3 back-to-back valid words.
  - Two accepted; in_ready=0 from the 3rd cycle.
  - Raise out_ready: outputs appear in order.
  - The 3rd word is accepted one cycle after the first pop.
- Flush: 2 entries buffered plus in_valid=1 with flush=1 → next cycle out_valid=0, in_ready=1, and that input never emerges.
- Errors:
  - Auto mode, 0x0000007F → out_fmt_err=1, out_imm=0, out_fmt=0.
  - AUTO_DECODE=0, ext_op=0000011 → out_fmt_err=1.
  - AUTO_DECODE=0, ext_op=0001000 with 0xFE000EE3 → 0xFFFFFFFC.
- XLEN=64: 0x800002B7 → 0xFFFFFFFF80000000; 0x03F09093 (slli 63) → 0x3F.
- Reset: assert rstn=0 mid-stream with 2 entries → out_valid=0 asynchronously; after release, next input appears with latency 1.
